serdes_tx_sched: RTL and testbench
==================================

Name: serdes_tx_sched

Overview:
Round-robin scheduler that shares one 32-bit parallel-to-serial lane among N_REQ word requesters. It accepts one word per grant, pulses the serializer's load enable with that word, then counts out the 32 shift cycles. It marks each bit-time with a frame-valid strobe and the source index, so the receive side can demultiplexe. It sits directly in front of the serializer in the serdes TX path.

Parameters:
N_REQ, 4, number of requesters (2..16)
WORD_W, 32, serialized word width; must equal the serializer buffer width
GAP_CYCLES, 0, idle cycles inserted after each frame before the next arbitration (0..15)

Ports:
clk  in  1  single clock
rst  in  1  synchronous, active-high reset
enable  in  1  scheduler run; when low, no new grant is issued (the current frame completes)
req_valid  in  N_REQ  per-requester word available
req_data  in  N_REQ*WORD_W  requester i word at [i*WORD_W +: WORD_W]
req_ready  out  N_REQ  one-hot accept strobe (combinational); the word is taken when valid&ready
ser_load  out  1  load enable to the serializer
ser_data  out  WORD_W  word presented to the serializer; registered; held stable through the frame
frame_valid  out  1  high exactly in cycles where the serial output carries a frame bit
frame_src  out  clog2(N_REQ)  index of the requester owning the current frame
frame_last  out  1  high with frame_valid on the bit-0 cycle
busy  out  1  state != IDLE

Behaviour:
- Reset (sync, rst=1 at posedge): state=IDLE, rr_ptr=0, bit_cnt=0, gap_cnt=0. Outputs: ser_load=0, ser_data=0, frame_valid=0, frame_src=0, frame_last=0, busy=0, req_ready=0. Reset mid-frame aborts the frame immediately, with no completion.
- Serializer contract: the serializer captures ser_data at the posedge ending a ser_load cycle. It shifts left once per following cycle and outputs MSB first. Bit 31 appears in the cycle after load; bit 0 appears 32 cycles after load.
- FSM states: IDLE, LOAD, SHIFT, GAP.
  - IDLE: if enable && |req_valid, grant g = first valid index at or after rr_ptr (wrapping); otherwise stay in IDLE.
    - req_ready[g]=1 this cycle only.
    - On the edge: ser_data<=req_data[g], frame_src<=g, rr_ptr<=(g+1) mod N_REQ, go to LOAD.
  - LOAD: ser_load=1 for exactly 1 cycle; bit_cnt<=WORD_W-1; go to SHIFT.
  - SHIFT: frame_valid=1; bit_cnt decrements each cycle. frame_last=1 when bit_cnt==0.
    - At bit_cnt==0: go to GAP if GAP_CYCLES>0 (gap_cnt<=GAP_CYCLES-1), otherwise go to IDLE.
  - GAP: all strobes low; decrement gap_cnt; go to IDLE at 0.
- Frame period is 2+WORD_W+GAP_CYCLES cycles from accept to next possible accept (34 at defaults).
- req_ready is never asserted outside IDLE, never more than one bit at a time, and never while enable=0.
- frame_valid, frame_last and ser_load are decoded from registered state/counters and are glitch-free.
- ser_data and frame_src hold their values from LOAD until the next accept.
- enable dropping during LOAD/SHIFT/GAP does not truncate the frame; it blocks only the next grant.
- A requester dropping req_valid after acceptance has no effect on the current frame.
- The round-robin pointer advances only on a grant. A lone requester gets back-to-back grants.
- Counter widths: bit_cnt is clog2(WORD_W) bits; gap_cnt is 4 bits. Neither wraps below 0; state changes at 0.

Decomposition:
- serdes_pkg: WORD_W default, the state enum {IDLE, LOAD, SHIFT, GAP}, and the clog2-based index-width helper constant.
- Sub-module rr_arbiter (N_REQ, req vector, ptr in → one-hot grant plus index, any_grant). It is purely combinational; the pointer register stays in serdes_tx_sched.

Test Plan:
- Reset with req_valid=4'b0001 held → all outputs 0 for the reset cycles. Accept 1 cycle after rst falls; ser_load 1 cycle later; frame_valid high for exactly 32 cycles with frame_src=0.
- All four valid continuously with data 0xA5A5_0000+i → grant order 0,1,2,3,0,… at a 34-cycle accept period. A serializer model reproduces each word MSB first, and frame_last lands on the 32nd bit.
- Only requester 2 valid with ptr=3 → wrap-around grant to 2; ptr becomes 3. A next grant to 2 again after 34 cycles.
- GAP_CYCLES=3 with continuous requests → 37-cycle period; frame_valid low for 3+2 cycles between frames.
- enable cleared at bit 10 of a frame → the frame completes all 32 bits; no req_ready while enable=0. Re-enable → grant on the first IDLE cycle.
- rst asserted at bit 16 → next cycle frame_valid=0, state IDLE, rr_ptr=0. The first post-reset grant goes to the lowest valid index.

Source files
------------

// File: rtl/serdes_pkg.sv
// rtl/serdes_pkg.sv - shared types and width helpers for the serdes TX scheduler
package serdes_pkg;

  localparam int WORD_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IDX_W_DEF = idx_w(4);

endpackage

// File: rtl/serdes_tx_sched_if.sv
// rtl/serdes_tx_sched_if.sv - requester and serializer-side signals of the TX scheduler
interface serdes_tx_sched_if
  import serdes_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int WORD_W = WORD_W_DEF
);
  localparam int IW = idx_w(N_REQ);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*WORD_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic                    ser_load;
  logic [WORD_W-1:0]       ser_data;
  logic                    frame_valid;
  logic [IW-1:0]           frame_src;
  logic                    frame_last;
  logic                    busy;

  modport master (
    output req_valid, req_data,
    input  req_ready, ser_load, ser_data, frame_valid, frame_src, frame_last, busy
  );

  modport slave (
    input  req_valid, req_data,
    output req_ready, ser_load, ser_data, frame_valid, frame_src, frame_last, busy
  );

endinterface

// File: rtl/serdes_tx_sched_rr_arbiter.sv
// rtl/serdes_tx_sched_rr_arbiter.sv - combinational round-robin pick starting at ptr
module rr_arbiter
  import serdes_pkg::*;
#(
  parameter int  N_REQ = 4,
  localparam int IW    = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    grant_idx,
  output logic             any_grant
);

  // k walks the priority order from ptr; j keeps every bit select constant
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      for (int j = 0; j < N_REQ; j++) begin
        if (!any_grant && req[j] && (j == ((int'(ptr) + k) % N_REQ))) begin
          grant[j]  = 1'b1;
          grant_idx = IW'(j);
          any_grant = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/serdes_tx_sched.sv
// rtl/serdes_tx_sched.sv - round-robin word scheduler in front of a 32-bit serializer
module serdes_tx_sched
  import serdes_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int WORD_W     = WORD_W_DEF,
  parameter int GAP_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  serdes_tx_sched_if.slave  bus
);

  localparam int             IW       = idx_w(N_REQ);
  localparam int             BW       = idx_w(WORD_W);
  localparam logic [BW-1:0]  BIT_INIT = BW'(WORD_W - 1);
  localparam logic [3:0]     GAP_INIT = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  state_t            state, state_nxt;
  logic [IW-1:0]     rr_ptr;
  logic [IW-1:0]     grant_idx;
  logic [N_REQ-1:0]  grant;
  logic              any_grant;
  logic              accept;
  logic [BW-1:0]     bit_cnt;
  logic [3:0]        gap_cnt;
  logic [WORD_W-1:0] ser_data_q;
  logic [IW-1:0]     frame_src_q;
  logic [WORD_W-1:0] words [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_words
    assign words[i] = bus.req_data[i*WORD_W +: WORD_W];
  end

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req       (bus.req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  // rst gates the combinational accept so no strobe leaks during reset
  assign accept = (state == IDLE) && enable && any_grant && !rst;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr      <= '0;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      ser_data_q  <= '0;
      frame_src_q <= '0;
    end else begin
      if (accept) begin
        ser_data_q  <= words[grant_idx];
        frame_src_q <= grant_idx;
        rr_ptr      <= IW'((int'(grant_idx) + 1) % N_REQ);
      end
      case (state)
        LOAD:  bit_cnt <= BIT_INIT;
        SHIFT: begin
          if (bit_cnt != '0)        bit_cnt <= bit_cnt - 1'b1;
          else if (GAP_CYCLES > 0)  gap_cnt <= GAP_INIT;
        end
        GAP:   if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = LOAD;
      LOAD:  state_nxt = SHIFT;
      SHIFT: if (bit_cnt == '0) state_nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
      GAP:   if (gap_cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready   = accept ? grant : '0;
    bus.ser_load    = (state == LOAD);
    bus.frame_valid = (state == SHIFT);
    bus.frame_last  = (state == SHIFT) && (bit_cnt == '0);
    bus.busy        = (state != IDLE);
    bus.ser_data    = ser_data_q;
    bus.frame_src   = frame_src_q;
  end

endmodule

// File: tb/tb_serdes_tx_sched.sv
// tb/tb_serdes_tx_sched.sv - directed tables plus randomized run against a timing model
module tb_serdes_tx_sched;
  import serdes_pkg::*;

  localparam int N = 4;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic [N-1:0] valid;
  logic [W-1:0] data [N];

  always #5 clk = ~clk;

  serdes_tx_sched_if #(.N_REQ(N), .WORD_W(W)) bif0 ();
  serdes_tx_sched_if #(.N_REQ(N), .WORD_W(W)) bif3 ();

  assign bif0.req_valid = valid;
  assign bif0.req_data  = {data[3], data[2], data[1], data[0]};
  assign bif3.req_valid = valid;
  assign bif3.req_data  = {data[3], data[2], data[1], data[0]};

  serdes_tx_sched #(.N_REQ(N), .WORD_W(W), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .enable(enable), .bus(bif0.slave));
  serdes_tx_sched #(.N_REQ(N), .WORD_W(W), .GAP_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .enable(enable), .bus(bif3.slave));

  int errors = 0;
  int checks = 0;
  int now    = 0;

  // model: each frame is just an accept time, a word and an owner
  int          m_ptr  [2];
  int          m_free [2];
  int          m_load [2];
  int          m_src  [2];
  logic [31:0] m_word [2];
  logic [31:0] sh     [2];

  int gt0[$], gi0[$], gt3[$], gi3[$];

  logic [3:0] ob_rdy;
  logic       ob_load, ob_fv, ob_busy;

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] valid;
    int         rep;
    logic [3:0] exp_rdy;
    logic       exp_load;
    logic       exp_fv;
    logic       exp_busy;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0d actual=%0h expected=%0h", name, now, act, exp);
    end
  endtask

  task automatic step(input bit chk_on);
    logic [3:0]  o_rdy [2];
    logic        o_load [2], o_fv [2], o_last [2], o_busy [2];
    logic [1:0]  o_src [2];
    logic [31:0] o_sd [2];
    @(negedge clk);
    o_rdy[0] = bif0.req_ready;  o_rdy[1] = bif3.req_ready;
    o_load[0] = bif0.ser_load;  o_load[1] = bif3.ser_load;
    o_fv[0] = bif0.frame_valid; o_fv[1] = bif3.frame_valid;
    o_last[0] = bif0.frame_last; o_last[1] = bif3.frame_last;
    o_busy[0] = bif0.busy;      o_busy[1] = bif3.busy;
    o_src[0] = bif0.frame_src;  o_src[1] = bif3.frame_src;
    o_sd[0] = bif0.ser_data;    o_sd[1] = bif3.ser_data;
    ob_rdy = o_rdy[0]; ob_load = o_load[0]; ob_fv = o_fv[0]; ob_busy = o_busy[0];
    for (int d = 0; d < 2; d++) begin
      int         gap, g, oi;
      bit         can;
      logic [3:0] e_rdy;
      logic       e_load, e_fv, e_last, e_busy;
      string      p;
      p   = (d == 0) ? "g0" : "g3";
      gap = (d == 0) ? 0 : 3;
      can = !rst && enable && (now >= m_free[d]) && (valid != 0);
      g = -1;
      if (can)
        for (int k = 0; k < N; k++)
          if (g < 0 && valid[(m_ptr[d] + k) % N]) g = (m_ptr[d] + k) % N;
      e_rdy  = can ? (4'b0001 << g) : 4'b0000;
      e_load = (now == m_load[d]);
      e_fv   = (now > m_load[d]) && (now <= m_load[d] + W);
      e_last = (now == m_load[d] + W);
      e_busy = (now >= m_load[d]) && (now < m_free[d]);
      if (chk_on) begin
        chk({p, "_req_ready"}, 64'(o_rdy[d]), 64'(e_rdy));
        chk({p, "_ser_load"}, 64'(o_load[d]), 64'(e_load));
        chk({p, "_frame_valid"}, 64'(o_fv[d]), 64'(e_fv));
        chk({p, "_frame_last"}, 64'(o_last[d]), 64'(e_last));
        chk({p, "_busy"}, 64'(o_busy[d]), 64'(e_busy));
        chk({p, "_frame_src"}, 64'(o_src[d]), 64'(m_src[d]));
        chk({p, "_ser_data"}, 64'(o_sd[d]), 64'(m_word[d]));
        if (e_fv)
          chk({p, "_serial_bit"}, 64'(sh[d][31]), 64'(m_word[d][W - 1 - (now - m_load[d] - 1)]));
      end
      if (o_rdy[d] != 0) begin
        oi = 0;
        for (int k = 0; k < N; k++) if (o_rdy[d][k]) oi = k;
        if (d == 0) begin gt0.push_back(now); gi0.push_back(oi); end
        else        begin gt3.push_back(now); gi3.push_back(oi); end
      end
      if (rst) begin
        m_ptr[d] = 0; m_free[d] = now + 1; m_load[d] = -1000; m_src[d] = 0; m_word[d] = '0;
      end else if (can) begin
        m_ptr[d]  = (g + 1) % N;
        m_load[d] = now + 1;
        m_free[d] = now + 2 + W + gap;
        m_src[d]  = g;
        m_word[d] = data[g];
      end
      sh[d] = o_load[d] ? o_sd[d] : (sh[d] << 1);
    end
    now++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) step(1);
    rst = 1'b0;
    gt0.delete(); gi0.delete(); gt3.delete(); gi3.delete();
  endtask

  initial begin
    int fv_cnt, rdy_off;
    tbl[0] = '{1'b1, 1'b1, 4'b0001,  2, 4'b0000, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 4'b0001,  1, 4'b0001, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 4'b0001,  1, 4'b0000, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 1'b1, 4'b0000, 32, 4'b0000, 1'b0, 1'b1, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 4'b0000,  1, 4'b0000, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 4'b0001,  3, 4'b0000, 1'b0, 1'b0, 1'b0};

    for (int d = 0; d < 2; d++) begin
      m_ptr[d] = 0; m_free[d] = 0; m_load[d] = -1000; m_src[d] = 0; m_word[d] = '0; sh[d] = '0;
    end
    rst = 1'b1; enable = 1'b1; valid = 4'b0001;
    data[0] = 32'hDEAD_BEEF; data[1] = 32'h1357_9BDF; data[2] = 32'h8000_0001; data[3] = 32'h0F0F_F0F0;
    #1;
    step(0);

    for (int i = 0; i < 6; i++) begin
      for (int r = 0; r < tbl[i].rep; r++) begin
        rst = tbl[i].rst; enable = tbl[i].en; valid = tbl[i].valid;
        step(1);
        chk($sformatf("tbl%0d_req_ready", i), 64'(ob_rdy), 64'(tbl[i].exp_rdy));
        chk($sformatf("tbl%0d_ser_load", i), 64'(ob_load), 64'(tbl[i].exp_load));
        chk($sformatf("tbl%0d_frame_valid", i), 64'(ob_fv), 64'(tbl[i].exp_fv));
        chk($sformatf("tbl%0d_busy", i), 64'(ob_busy), 64'(tbl[i].exp_busy));
      end
    end

    enable = 1'b1; valid = 4'b0000;
    do_reset();
    for (int i = 0; i < N; i++) data[i] = 32'hA5A5_0000 + 32'(i);
    valid = 4'b1111;
    repeat (160) step(1);
    chk("rr_count_g0", 64'(gi0.size() >= 5), 64'd1);
    chk("rr_count_g3", 64'(gi3.size() >= 5), 64'd1);
    if (gi0.size() >= 5 && gi3.size() >= 5)
      for (int k = 0; k < 5; k++) begin
        chk($sformatf("rr_order_g0_%0d", k), 64'(gi0[k]), 64'(k % N));
        chk($sformatf("rr_order_g3_%0d", k), 64'(gi3[k]), 64'(k % N));
        if (k > 0) begin
          chk($sformatf("rr_period_g0_%0d", k), 64'(gt0[k] - gt0[k-1]), 64'd34);
          chk($sformatf("rr_period_g3_%0d", k), 64'(gt3[k] - gt3[k-1]), 64'd37);
        end
      end

    valid = 4'b0000;
    do_reset();
    valid = 4'b0100;
    repeat (75) step(1);
    chk("lone_count_g0", 64'(gi0.size()), 64'd3);
    if (gi0.size() == 3)
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("lone_idx_g0_%0d", k), 64'(gi0[k]), 64'd2);
        if (k > 0) chk($sformatf("lone_period_g0_%0d", k), 64'(gt0[k] - gt0[k-1]), 64'd34);
      end

    valid = 4'b0000;
    do_reset();
    valid = 4'b1111;
    fv_cnt = 0; rdy_off = 0;
    for (int s = 0; s < 63; s++) begin
      enable = (s < 23);
      step(1);
      if (ob_fv) fv_cnt++;
      if (!enable && ob_rdy != 0) rdy_off++;
    end
    chk("en_drop_frame_bits", 64'(fv_cnt), 64'd32);
    chk("en_drop_no_ready", 64'(rdy_off), 64'd0);
    enable = 1'b1;
    step(1);
    chk("en_resume_grant", 64'(ob_rdy), 64'b0010);

    valid = 4'b0000;
    do_reset();
    valid = 4'b1110;
    repeat (17) step(1);
    chk("rst_mid_in_frame", 64'(ob_fv), 64'd1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(1);
    chk("rst_mid_fv", 64'(ob_fv), 64'd0);
    chk("rst_mid_busy", 64'(ob_busy), 64'd0);
    chk("rst_mid_grant", 64'(ob_rdy), 64'b0010);

    for (int c = 0; c < 3000; c++) begin
      rst    = ($urandom_range(0, 299) == 0);
      enable = ($urandom_range(0, 9) != 0);
      valid  = 4'($urandom());
      if ($urandom_range(0, 3) == 0)
        for (int i = 0; i < N; i++) data[i] = $urandom();
      step(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
